// File: rtl/fft_out_ctrl.sv
// fft_out_ctrl: checks FFT output framing and writes {bin_idx, re^2+im^2} to the spectrum FIFO.
// Two-stage squaring pipeline; done/err pulses stay aligned with the deciding beat's write.
module fft_out_ctrl #(
  parameter int N_POINT = 512,
  parameter int DW      = 16,
  parameter int CW      = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fft_out_valid_i,
  input  logic                 fft_out_sop_i,
  input  logic                 fft_out_eop_i,
  input  logic signed [DW-1:0] fft_out_real_i,
  input  logic signed [DW-1:0] fft_out_imag_i,
  output logic                 fft_out_ready_o,
  input  logic                 fifo_afull_i,
  output logic                 fifo_wrreq_o,
  output logic [2*DW+CW-1:0]   fifo_data_o,
  output logic                 frame_done_o,
  output logic                 frame_err_o
);
  typedef enum logic {IDLE, RECV} state_t;
  localparam logic [CW-1:0] LAST = CW'(N_POINT - 1);
  localparam logic SINGLE = (N_POINT == 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, bin_d, bin1_q;
  logic acc, wr_d, done_d, err_d, v1_q, done1_q, err1_q;
  logic signed [2*DW-1:0] pr_q, pi_q;
  assign acc = fft_out_valid_i & fft_out_ready_o;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = cnt_q;
    wr_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (acc) begin
      if (fft_out_sop_i) begin
        wr_d  = 1'b1;
        bin_d = '0;
        if (fft_out_eop_i) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = SINGLE && state_q == IDLE;
          err_d   = !done_d;
        end else begin
          state_d = RECV;
          cnt_d   = CW'(1);
          err_d   = state_q == RECV;
        end
      end else if (state_q == IDLE) begin
        err_d = 1'b1;
      end else begin
        wr_d = 1'b1;
        if (fft_out_eop_i || cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = fft_out_eop_i && cnt_q == LAST;
          err_d   = !done_d;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end
  // ready is registered; the FIFO's 4-word margin absorbs it plus the two pipeline stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      fft_out_ready_o <= 1'b0;
      v1_q            <= 1'b0;
      done1_q         <= 1'b0;
      err1_q          <= 1'b0;
      bin1_q          <= '0;
      pr_q            <= '0;
      pi_q            <= '0;
      fifo_wrreq_o    <= 1'b0;
      fifo_data_o     <= '0;
      frame_done_o    <= 1'b0;
      frame_err_o     <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      fft_out_ready_o <= ~fifo_afull_i;
      v1_q            <= wr_d;
      done1_q         <= done_d;
      err1_q          <= err_d;
      if (acc) begin
        bin1_q <= bin_d;
        pr_q   <= fft_out_real_i * fft_out_real_i;
        pi_q   <= fft_out_imag_i * fft_out_imag_i;
      end
      fifo_wrreq_o <= v1_q;
      frame_done_o <= done1_q;
      frame_err_o  <= err1_q;
      if (v1_q) fifo_data_o <= {bin1_q, $unsigned(pr_q) + $unsigned(pi_q)};
    end
  end
endmodule

// File: tb/tb_fft_out_ctrl.sv
// tb_fft_out_ctrl: table vectors plus frame sequences; expected writes/pulses are queued at
// accept time and matched against DUT output exactly two cycles later.
module tb_fft_out_ctrl;
  localparam int N = 512, DW = 16, CW = 10;
  logic clk = 0, rst_n = 0, valid = 0, sop = 0, eop = 0, afull = 0;
  logic ready, wrreq, done, err;
  logic signed [DW-1:0] re = 0, im = 0;
  logic [2*DW+CW-1:0] data;
  int checks = 0, errors = 0, cyc = 0, tc = 0;
  bit tog_en = 0;
  typedef struct {bit wr; int bin; logic [31:0] mag; bit done; bit err; int due;} exp_t;
  typedef struct {bit sop; bit eop; logic signed [15:0] re; logic signed [15:0] im; bit wr; int bin; bit done; bit err;} vec_t;
  exp_t q[$];
  vec_t vecs[7];

  fft_out_ctrl #(.N_POINT(N), .DW(DW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .fft_out_valid_i(valid), .fft_out_sop_i(sop), .fft_out_eop_i(eop),
    .fft_out_real_i(re), .fft_out_imag_i(im), .fft_out_ready_o(ready), .fifo_afull_i(afull),
    .fifo_wrreq_o(wrreq), .fifo_data_o(data), .frame_done_o(done), .frame_err_o(err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tog_en) begin
      tc = tc + 1;
      if (tc % 7 == 0) afull = ~afull;
    end else begin
      tc = 0;
      afull = 0;
    end
  end

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      while (q.size() > 0 && q[0].due < cyc) begin
        checks++; errors++;
        $display("FAIL missed_output bin=%0d due=%0d actual=none required=wr%0b/done%0b/err%0b", q[0].bin, q[0].due, q[0].wr, q[0].done, q[0].err);
        void'(q.pop_front());
      end
      if (wrreq || done || err) begin
        checks++;
        if (q.size() == 0 || q[0].due != cyc) begin
          errors++;
          $display("FAIL unexpected_output cyc=%0d actual wr=%0b done=%0b err=%0b data=%h required=none", cyc, wrreq, done, err, data);
        end else begin
          e = q.pop_front();
          if (wrreq !== e.wr || done !== e.done || err !== e.err ||
              (e.wr && (data[2*DW+CW-1:2*DW] !== CW'(e.bin) || data[2*DW-1:0] !== e.mag))) begin
            errors++;
            $display("FAIL output cyc=%0d actual wr=%0b bin=%0d mag=%h done=%0b err=%0b required wr=%0b bin=%0d mag=%h done=%0b err=%0b",
                     cyc, wrreq, data[2*DW+CW-1:2*DW], data[2*DW-1:0], done, err, e.wr, e.bin, e.mag, e.done, e.err);
          end
        end
      end
    end
  end

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] r);
    checks++;
    if (a !== r) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", n, a, r);
    end
  endtask

  task automatic beat(input bit s, input bit e_, input logic signed [15:0] r, input logic signed [15:0] i,
                      input bit wr, input int bin, input bit dn, input bit er);
    exp_t x;
    longint m;
    int t = 0;
    valid = 1; sop = s; eop = e_; re = r; im = i;
    while (!ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout actual=0 required=1");
    end else begin
      m = longint'(r) * longint'(r) + longint'(i) * longint'(i);
      x.wr = wr; x.bin = bin; x.mag = m[31:0]; x.done = dn; x.err = er; x.due = cyc + 2;
      q.push_back(x);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    valid = 0; sop = 0; eop = 0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input int len, input bit with_eop, input bit first_err, input bit rnd);
    for (int i = 0; i < len; i++) begin
      bit e_;
      logic signed [15:0] r, m;
      e_ = with_eop && i == len - 1;
      r = rnd ? 16'($urandom) : 16'sd3;
      m = rnd ? 16'($urandom) : -16'sd4;
      beat(i == 0, e_, r, m, 1'b1, i, e_ && i == N - 1,
           (i == 0 && first_err) || (e_ && i < N - 1) || (!e_ && i == N - 1));
    end
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 16'sd1, 16'sd1, 1'b0, 0, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 16'sh8000, 16'sh8000, 1'b1, 0, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 16'sd5, 16'sd12, 1'b1, 0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, -16'sd7, 16'sd0, 1'b1, 1, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 16'sd1, 16'sd2, 1'b1, 0, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 16'sh7fff, 16'sh8000, 1'b1, 1, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 16'sd2, 16'sd2, 1'b0, 0, 1'b0, 1'b1};
    repeat (3) @(negedge clk);
    chk("reset_outputs", {ready, wrreq, done, err, data}, 64'd0);
    rst_n = 1;
    @(negedge clk);
    chk("ready_after_reset", 64'(ready), 64'd1);
    send_frame(N, 1, 0, 0);
    idle(5);
    for (int i = 0; i < 7; i++)
      beat(vecs[i].sop, vecs[i].eop, vecs[i].re, vecs[i].im, vecs[i].wr, vecs[i].bin, vecs[i].done, vecs[i].err);
    idle(5);
    send_frame(101, 1, 0, 0);
    send_frame(N, 1, 0, 1);
    idle(5);
    tog_en = 1;
    send_frame(N, 1, 0, 1);
    tog_en = 0;
    idle(5);
    send_frame(300, 0, 0, 1);
    send_frame(N, 1, 1, 1);
    idle(3);
    send_frame(N, 0, 0, 1);
    beat(0, 0, 16'sd9, 16'sd9, 0, 0, 0, 1);
    idle(5);
    send_frame(200, 0, 0, 1);
    rst_n = 0;
    valid = 0; sop = 0; eop = 0;
    q.delete();
    #1;
    chk("midframe_reset_outputs", {ready, wrreq, done, err, data}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    send_frame(N, 1, 0, 0);
    idle(6);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
